mem_arbiter: RTL

//  Sits directly upstream of the unified memory and is its only master: drives addr, re, we and the tri-state data bus.

---
 rtl/mem_arbiter.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: sole master of the unified memory. Arbitrates fetch against
// load/store, aligns sub-word accesses and performs read-modify-write for SB/SH.
module mem_arbiter #(
   parameter int ADDR_WIDTH = 16
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  i_req,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   output logic                  i_gnt,
   output logic                  i_valid,
   output logic [31:0]           i_rdata,
   output logic                  i_err,
   input  logic                  d_req,
   input  logic                  d_we,
   input  logic [1:0]            d_size,
   input  logic                  d_unsigned,
   input  logic [ADDR_WIDTH-1:0] d_addr,
   input  logic [31:0]           d_wdata,
   output logic                  d_gnt,
   output logic                  d_valid,
   output logic [31:0]           d_rdata,
   output logic                  d_err,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   inout  wire  [31:0]           mem_data,
   output logic                  mem_re,
   output logic                  mem_we
);

   typedef enum logic [1:0] {
      IDLE,
      I_RD,
      D_RD,
      D_WR
   } state_t;

   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;

   state_t r_state;
   state_t w_next;

   logic                  r_last_d;
   logic [ADDR_WIDTH-3:0] r_waddr;
   logic                  r_we;
   logic                  r_uns;
   logic [1:0]            r_size;
   logic [1:0]            r_lane;
   logic [31:0]           r_wdata;
   logic [31:0]           r_irdata;
   logic [31:0]           r_drdata;
   logic                  r_ivalid;
   logic                  r_dvalid;
   logic                  r_ierr;
   logic                  r_derr;

   logic        w_pick_i;
   logic        w_pick_d;
   logic        w_ierr;
   logic        w_derr;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_load;
   logic [31:0] w_merge;

   // Round-robin: r_last_d=1 means data won last, so fetch wins a tie.
   always_comb begin
      w_pick_i = i_req & (~d_req | r_last_d);
      w_pick_d = d_req & ~w_pick_i;
      w_ierr   = (i_addr[1:0] != 2'b00);
      case (d_size)
         SZ_B:    w_derr = 1'b0;
         SZ_H:    w_derr = d_addr[0];
         SZ_W:    w_derr = (d_addr[1:0] != 2'b00);
         default: w_derr = 1'b1;
      endcase
   end

   always_comb begin
      w_next = r_state;
      i_gnt  = 1'b0;
      d_gnt  = 1'b0;
      mem_re = 1'b0;
      mem_we = 1'b0;
      unique case (r_state)
         IDLE: begin
            i_gnt = w_pick_i;
            d_gnt = w_pick_d;
            if (w_pick_i && !w_ierr) begin
               w_next = I_RD;
            end else if (w_pick_d && !w_derr) begin
               w_next = (d_we && d_size == SZ_W) ? D_WR : D_RD;
            end
         end
         I_RD: begin
            mem_re = 1'b1;
            w_next = IDLE;
         end
         D_RD: begin
            mem_re = 1'b1;
            w_next = r_we ? D_WR : IDLE;
         end
         D_WR: begin
            mem_we = 1'b1;
            w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
      // No grant and no memory access while reset is asserted.
      if (!reset_n) begin
         i_gnt  = 1'b0;
         d_gnt  = 1'b0;
         mem_re = 1'b0;
         mem_we = 1'b0;
         w_next = IDLE;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) r_state <= IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_byte = mem_data[8*r_lane +: 8];
      w_half = r_lane[1] ? mem_data[31:16] : mem_data[15:0];
      case (r_size)
         SZ_B: begin
            w_load = r_uns ? {24'b0, w_byte}
                           : {{24{w_byte[7]}}, w_byte};
         end
         SZ_H: begin
            w_load = r_uns ? {16'b0, w_half}
                           : {{16{w_half[15]}}, w_half};
         end
         default: w_load = mem_data;
      endcase
      w_merge = mem_data;
      if (r_size == SZ_B) w_merge[8*r_lane +: 8] = r_wdata[7:0];
      else                w_merge[16*r_lane[1] +: 16] = r_wdata[15:0];
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_last_d <= 1'b1;
         r_waddr  <= '0;
         r_we     <= 1'b0;
         r_uns    <= 1'b0;
         r_size   <= 2'b00;
         r_lane   <= 2'b00;
         r_wdata  <= 32'b0;
         r_irdata <= 32'b0;
         r_drdata <= 32'b0;
         r_ivalid <= 1'b0;
         r_dvalid <= 1'b0;
         r_ierr   <= 1'b0;
         r_derr   <= 1'b0;
      end else begin
         r_ivalid <= 1'b0;
         r_dvalid <= 1'b0;
         r_ierr   <= 1'b0;
         r_derr   <= 1'b0;
         if (i_gnt) begin
            r_last_d <= 1'b0;
            r_ierr   <= w_ierr;
            r_waddr  <= i_addr[ADDR_WIDTH-1:2];
         end
         if (d_gnt) begin
            r_last_d <= 1'b1;
            r_derr   <= w_derr;
            r_waddr  <= d_addr[ADDR_WIDTH-1:2];
            r_we     <= d_we;
            r_size   <= d_size;
            r_uns    <= d_unsigned;
            r_lane   <= d_addr[1:0];
            r_wdata  <= d_wdata;
         end
         case (r_state)
            I_RD: begin
               r_irdata <= mem_data;
               r_ivalid <= 1'b1;
            end
            D_RD: begin
               if (r_we) begin
                  r_wdata <= w_merge;
               end else begin
                  r_drdata <= w_load;
                  r_dvalid <= 1'b1;
               end
            end
            D_WR:    r_dvalid <= 1'b1;
            default: ;
         endcase
      end
   end

   assign mem_addr = {r_waddr, 2'b00};
   assign mem_data = mem_we ? r_wdata : 32'bz;
   assign i_valid  = r_ivalid;
   assign i_rdata  = r_irdata;
   assign i_err    = r_ierr;
   assign d_valid  = r_dvalid;
   assign d_rdata  = r_drdata;
   assign d_err    = r_derr;

endmodule
